// File: rtl/key_step_debounce_if.sv
// Key/switch conditioning bundle between pushbutton inputs and the adder FSM.
// Latency: none (wires only).
// Backpressure: none; step is a fire-and-forget pulse.
interface key_step_debounce_if #(
    parameter int SW_W = 8
);
    logic            key_n;
    logic [SW_W-1:0] sw_raw;
    logic            step;
    logic [SW_W-1:0] sw_snap;
    logic            pressed;
    logic [7:0]      press_count;

    modport master (
        output key_n,
        output sw_raw,
        input  step,
        input  sw_snap,
        input  pressed,
        input  press_count
    );

    modport slave (
        input  key_n,
        input  sw_raw,
        output step,
        output sw_snap,
        output pressed,
        output press_count
    );
endinterface

// File: rtl/key_step_debounce.sv
// Sync + debounce of the active-low step key; one step pulse per press with switch snapshot (auto-repeat under KEY_STEP_AUTO_REPEAT_EN).
// Latency: step rises DEBOUNCE_CYCLES+2 edges after key_n is first sampled low.
// Backpressure: none; consumer must take step/sw_snap on the pulse cycle.
module key_step_debounce #(
    parameter int SW_W            = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset,
    key_step_debounce_if.slave   io
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

    // Period of 1 would make step high on consecutive cycles.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("key_step_debounce: illegal timing parameters");
    end

    logic            key_m_q;
    logic            key_s_q;
    logic [SW_W-1:0] sw_m_q;
    logic [SW_W-1:0] sw_s_q;

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [31:0]     cnt_q;
    logic [31:0]     cnt_d;
    logic            fire_d;
    logic            step_q;
    logic [SW_W-1:0] sw_snap_q;
    logic [7:0]      count_q;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_m_q <= 1'b1;
            key_s_q <= 1'b1;
            sw_m_q  <= '0;
            sw_s_q  <= '0;
        end else begin
            key_m_q <= io.key_n;
            key_s_q <= key_m_q;
            sw_m_q  <= io.sw_raw;
            sw_s_q  <= sw_m_q;
        end
    end

`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam logic [31:0] RPT_DLY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_PER_LAST = 32'(REPEAT_PERIOD - 1);

    // Set once the first repeat has fired; selects period over initial delay.
    logic rep_q;
    logic rep_d;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!key_s_q) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (key_s_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
`ifdef KEY_STEP_AUTO_REPEAT_EN
                    rep_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HELD: begin
                if (key_s_q) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
`ifdef KEY_STEP_AUTO_REPEAT_EN
                    if (cnt_q == (rep_q ? RPT_PER_LAST : RPT_DLY_LAST)) begin
                        fire_d = 1'b1;
                        cnt_d  = '0;
                        rep_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            S_RELEASE_WAIT: begin
                if (!key_s_q) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
                    rep_d   = 1'b0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            sw_snap_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= fire_d;
            if (fire_d) begin
                sw_snap_q <= sw_s_q;
                count_q   <= count_q + 8'd1;
            end
        end
    end

    assign io.step        = step_q;
    assign io.sw_snap     = sw_snap_q;
    assign io.pressed     = (state_q == S_HELD) || (state_q == S_RELEASE_WAIT);
    assign io.press_count = count_q;

endmodule

// File: tb/tb_key_step_debounce.sv
// Directed bench for key_step_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Edge t is the first edge that samples a new key_n level; step is expected after edge t+6.
module tb_key_step_debounce;

    logic CLOCK_50 = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_cnt;

    key_step_debounce_if #(.SW_W(8)) bus ();

    key_step_debounce #(
        .SW_W            (8),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .io       (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Ticks until step is seen; n = tick index, or -1 on timeout.
    task automatic wait_step(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc && n < 0; i++) begin
            tick();
            if (bus.step === 1'b1) n = i;
        end
    endtask

    // Ticks until pressed drops; n = tick index or -1, steps = pulses seen meanwhile.
    task automatic wait_release(input int max_cyc, output int n, output int steps);
        n = -1;
        steps = 0;
        for (int i = 1; i <= max_cyc && n < 0; i++) begin
            tick();
            if (bus.step === 1'b1) steps++;
            if (bus.pressed === 1'b0) n = i;
        end
    endtask

    task automatic test_reset();
        int n;
        int s;
        Reset = 1'b1;
        bus.key_n = 1'b0;
        bus.sw_raw = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.step !== 1'b0) begin
                bad++;
                $display("FAIL reset_step cycle %0d: got %b want 0", i, bus.step);
            end
        end
        total++;
        if (bus.pressed !== 1'b0) begin
            bad++;
            $display("FAIL reset_pressed: got %b want 0", bus.pressed);
        end
        total++;
        if (bus.press_count !== 8'h00 || bus.sw_snap !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs: got cnt=%h snap=%h want 00 00", bus.press_count, bus.sw_snap);
        end
        Reset = 1'b0;
        tick();
        wait_step(20, n);
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL reset_held_key_latency: got %0d want 6", n);
        end
        total++;
        if (bus.sw_snap !== 8'hA5 || bus.press_count !== 8'h01 || bus.pressed !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_step: got snap=%h cnt=%h pr=%b want a5 01 1",
                     bus.sw_snap, bus.press_count, bus.pressed);
        end
        tick();
        total++;
        if (bus.step !== 1'b0) begin
            bad++;
            $display("FAIL step_one_cycle: got %b want 0", bus.step);
        end
        bus.key_n = 1'b1;
        wait_release(20, n, s);
        exp_cnt = 8'h01;
    endtask

    task automatic test_glitch();
        int steps = 0;
        int pr_seen = 0;
        tick();
        tick();
        bus.key_n = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 2) bus.key_n = 1'b1;
            if (bus.step === 1'b1) steps++;
            if (bus.pressed !== 1'b0) pr_seen++;
        end
        total++;
        if (steps !== 0 || pr_seen !== 0) begin
            bad++;
            $display("FAIL glitch_reject: got steps=%0d pressed_cycles=%0d want 0 0", steps, pr_seen);
        end
        total++;
        if (bus.press_count !== exp_cnt) begin
            bad++;
            $display("FAIL glitch_count: got %h want %h", bus.press_count, exp_cnt);
        end
    endtask

    task automatic test_clean_press();
        int n;
        int s;
        int extra = 0;
        int exp_extra;
        logic [7:0] exp_snap;
`ifdef KEY_STEP_AUTO_REPEAT_EN
        exp_extra = 2;
        exp_snap  = 8'hFF;
`else
        exp_extra = 0;
        exp_snap  = 8'h3C;
`endif
        bus.sw_raw = 8'h3C;
        bus.key_n = 1'b0;
        tick();
        wait_step(20, n);
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL clean_latency: got %0d want 6", n);
        end
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if (bus.sw_snap !== 8'h3C || bus.press_count !== exp_cnt) begin
            bad++;
            $display("FAIL clean_snap: got snap=%h cnt=%h want 3c %h", bus.sw_snap, bus.press_count, exp_cnt);
        end
        for (int i = 7; i <= 19; i++) begin
            tick();
            if (bus.step === 1'b1) extra++;
            if (i == 8) bus.sw_raw = 8'hFF;
            if (i == 12) begin
                total++;
                if (bus.sw_snap !== 8'h3C) begin
                    bad++;
                    $display("FAIL snap_hold: got %h want 3c", bus.sw_snap);
                end
            end
        end
        bus.key_n = 1'b1;
        tick();
        if (bus.step === 1'b1) extra++;
        wait_release(20, n, s);
        extra += s;
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL release_latency: got %0d want 6", n);
        end
        total++;
        if (extra !== exp_extra) begin
            bad++;
            $display("FAIL held_extra_steps: got %0d want %0d", extra, exp_extra);
        end
        exp_cnt = exp_cnt + 8'(exp_extra);
        total++;
        if (bus.sw_snap !== exp_snap || bus.press_count !== exp_cnt) begin
            bad++;
            $display("FAIL after_release: got snap=%h cnt=%h want %h %h",
                     bus.sw_snap, bus.press_count, exp_snap, exp_cnt);
        end
    endtask

    task automatic test_release_bounce();
        int n;
        int s;
        int steps = 0;
        int drops = 0;
        bus.key_n = 1'b0;
        tick();
        wait_step(20, n);
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL bounce_press_latency: got %0d want 6", n);
        end
        exp_cnt = exp_cnt + 8'd1;
        for (int i = 0; i < 3; i++) tick();
        bus.key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 1) bus.key_n = 1'b0;
            if (bus.step === 1'b1) steps++;
            if (bus.pressed !== 1'b1) drops++;
        end
        total++;
        if (steps !== 0 || drops !== 0) begin
            bad++;
            $display("FAIL release_bounce: got steps=%0d drops=%0d want 0 0", steps, drops);
        end
        bus.key_n = 1'b1;
        wait_release(20, n, s);
        total++;
        if (n !== 7 || s !== 0) begin
            bad++;
            $display("FAIL bounce_release: got ticks=%0d steps=%0d want 7 0", n, s);
        end
        total++;
        if (bus.press_count !== exp_cnt) begin
            bad++;
            $display("FAIL bounce_count: got %h want %h", bus.press_count, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        int n;
        int s;
        int timeouts = 0;
        Reset = 1'b1;
        bus.key_n = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        total++;
        if (bus.press_count !== 8'h00) begin
            bad++;
            $display("FAIL wrap_reset_count: got %h want 00", bus.press_count);
        end
        for (int p = 1; p <= 256; p++) begin
            bus.key_n = 1'b0;
            wait_step(20, n);
            if (n < 0) timeouts++;
            bus.key_n = 1'b1;
            wait_release(20, n, s);
            if (n < 0) timeouts++;
            if (p == 255) begin
                total++;
                if (bus.press_count !== 8'hFF) begin
                    bad++;
                    $display("FAIL count_255: got %h want ff", bus.press_count);
                end
            end
        end
        total++;
        if (bus.press_count !== 8'h00 || timeouts !== 0) begin
            bad++;
            $display("FAIL count_wrap: got cnt=%h timeouts=%0d want 00 0", bus.press_count, timeouts);
        end
    endtask

    task automatic test_auto_repeat();
        int n;
        int s;
        logic [31:0] mask = '0;
        logic [31:0] exp_mask = '0;
        logic [7:0]  exp_final;
`ifdef KEY_STEP_AUTO_REPEAT_EN
        for (int k = 10; k <= 28; k += 3) exp_mask[k] = 1'b1;
        exp_final = 8'd8;
`else
        exp_final = 8'd1;
`endif
        Reset = 1'b1;
        bus.key_n = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        bus.key_n = 1'b0;
        tick();
        wait_step(20, n);
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL repeat_first_latency: got %0d want 6", n);
        end
        for (int off = 1; off <= 29; off++) begin
            tick();
            if (bus.step === 1'b1) mask[off] = 1'b1;
            if (off == 27) bus.key_n = 1'b1;
        end
        total++;
        if (mask !== exp_mask) begin
            bad++;
            $display("FAIL repeat_offsets: got %h want %h", mask, exp_mask);
        end
        total++;
        if ((mask & (mask >> 1)) !== 32'h0) begin
            bad++;
            $display("FAIL step_consecutive: got %h want 0", mask & (mask >> 1));
        end
        wait_release(20, n, s);
        total++;
        if (bus.press_count !== exp_final || n < 0 || s !== 0) begin
            bad++;
            $display("FAIL repeat_count: got cnt=%0d ticks=%0d steps=%0d want %0d >0 0",
                     bus.press_count, n, s, exp_final);
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.key_n = 1'b1;
        bus.sw_raw = 8'h00;
        exp_cnt = 8'h00;
        test_reset();
        test_glitch();
        test_clean_press();
        test_release_bounce();
        test_wrap();
        test_auto_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
